// File: rtl/demux_12_2bits_pkg.sv
// demux_12_2bits_pkg: lane codes and default WIDTH/DEPTH shared by the demux, its mux peer and the bench
package demux_12_2bits_pkg;
  localparam int DEF_WIDTH = 2;
  localparam int DEF_DEPTH = 2;
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;
endpackage

// File: rtl/demux_12_2bits_if.sv
// demux_12_2bits_if: input word stream (data_in/valid_in/sel_in/ready_in) plus two lane outputs (data_outN/valid_outN/ready_outN)
interface demux_12_2bits_if
  import demux_12_2bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             sel_in;
  logic             ready_in;
  logic [WIDTH-1:0] data_out0;
  logic             valid_out0;
  logic             ready_out0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out1;
  logic             ready_out1;
  modport master (
    output data_in, valid_in, sel_in, ready_out0, ready_out1,
    input  ready_in, data_out0, valid_out0, data_out1, valid_out1
  );
  modport slave (
    input  data_in, valid_in, sel_in, ready_out0, ready_out1,
    output ready_in, data_out0, valid_out0, data_out1, valid_out1
  );
endinterface

// File: rtl/demux_12_2bits_lane_fifo.sv
// demux_lane_fifo: DEPTH-entry lane FIFO; ports clk, reset, push/push_data/full in, pop/head/empty out, head zero when empty
module demux_lane_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign head    = empty ? '0 : mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/demux_12_2bits.sv
// demux_12_2bits: steers each accepted word to lane 0/1 FIFO; ports clk, reset, bus (slave side of demux_12_2bits_if)
module demux_12_2bits
  import demux_12_2bits_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter bit AUTO_TOGGLE = 1'b1
) (
  input logic               clk,
  input logic               reset,
  demux_12_2bits_if.slave   bus
);
  logic sel_q, sel_d, t, accept, full0, full1, empty0, empty1;
  assign t            = AUTO_TOGGLE ? sel_q : bus.sel_in;
  assign bus.ready_in = t == LANE1 ? ~full1 : ~full0;
  assign accept       = bus.valid_in & bus.ready_in;
  assign sel_d        = accept ? ~sel_q : sel_q;
  assign bus.valid_out0 = ~empty0;
  assign bus.valid_out1 = ~empty1;
  always_ff @(posedge clk) sel_q <= reset ? LANE0 : sel_d;
  demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk(clk), .reset(reset),
    .push(accept & (t == LANE0)), .push_data(bus.data_in), .full(full0),
    .pop(bus.ready_out0), .head(bus.data_out0), .empty(empty0)
  );
  demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk(clk), .reset(reset),
    .push(accept & (t == LANE1)), .push_data(bus.data_in), .full(full1),
    .pop(bus.ready_out1), .head(bus.data_out1), .empty(empty1)
  );
endmodule

// File: tb/tb_demux_12_2bits.sv
// tb_demux_12_2bits: directed checks of the auto-toggle and explicit-select demux variants
module tb_demux_12_2bits;
  import demux_12_2bits_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  demux_12_2bits_if #(.WIDTH(DEF_WIDTH)) ba ();
  demux_12_2bits_if #(.WIDTH(DEF_WIDTH)) bs ();
  demux_12_2bits #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH), .AUTO_TOGGLE(1'b1)) u_auto (
    .clk(clk), .reset(reset), .bus(ba)
  );
  demux_12_2bits #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH), .AUTO_TOGGLE(1'b0)) u_sel (
    .clk(clk), .reset(reset), .bus(bs)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_a(input logic [1:0] d);
    ba.data_in = d;
    ba.valid_in = 1'b1;
    tick();
  endtask
  initial begin
    reset = 1'b1;
    ba.data_in = 2'b11; ba.valid_in = 1'b1; ba.sel_in = 1'b0;
    ba.ready_out0 = 1'b0; ba.ready_out1 = 1'b0;
    bs.data_in = 2'b11; bs.valid_in = 1'b1; bs.sel_in = 1'b1;
    bs.ready_out0 = 1'b0; bs.ready_out1 = 1'b0;
    // T1 reset
    tick(); tick();
    chk("t1_ready_in", 8'(ba.ready_in), 8'h1);
    chk("t1_valid_out0", 8'(ba.valid_out0), 8'h0);
    chk("t1_valid_out1", 8'(ba.valid_out1), 8'h0);
    chk("t1_data_out0", 8'(ba.data_out0), 8'h0);
    chk("t1_data_out1", 8'(ba.data_out1), 8'h0);
    chk("t1_sel_valid_out1", 8'(bs.valid_out1), 8'h0);
    reset = 1'b0; ba.valid_in = 1'b0; bs.valid_in = 1'b0;
    tick();
    chk("t1_nothing_pushed0", 8'(ba.valid_out0), 8'h0);
    chk("t1_nothing_pushed1", 8'(ba.valid_out1), 8'h0);
    // T2 alternation
    ba.ready_out0 = 1'b1; ba.ready_out1 = 1'b1;
    send_a(2'b01);
    chk("t2_w0_valid0", 8'(ba.valid_out0), 8'h1);
    chk("t2_w0_data0", 8'(ba.data_out0), 8'h1);
    chk("t2_w0_valid1", 8'(ba.valid_out1), 8'h0);
    send_a(2'b10);
    chk("t2_w1_valid1", 8'(ba.valid_out1), 8'h1);
    chk("t2_w1_data1", 8'(ba.data_out1), 8'h2);
    chk("t2_w1_valid0", 8'(ba.valid_out0), 8'h0);
    send_a(2'b11);
    chk("t2_w2_data0", 8'(ba.data_out0), 8'h3);
    chk("t2_w2_valid1", 8'(ba.valid_out1), 8'h0);
    send_a(2'b00);
    chk("t2_w3_valid1", 8'(ba.valid_out1), 8'h1);
    chk("t2_w3_data1", 8'(ba.data_out1), 8'h0);
    ba.valid_in = 1'b0;
    tick();
    chk("t2_drained", 8'({ba.valid_out0, ba.valid_out1}), 8'h0);
    // T3 back-pressure on lane 0
    ba.ready_out0 = 1'b0;
    send_a(2'b00);
    send_a(2'b01);
    send_a(2'b10);
    send_a(2'b11);
    ba.data_in = 2'b01;
    #1;
    chk("t3_ready_full", 8'(ba.ready_in), 8'h0);
    tick();
    chk("t3_ready_stalled", 8'(ba.ready_in), 8'h0);
    chk("t3_head0", 8'(ba.data_out0), 8'h0);
    ba.ready_out0 = 1'b1;
    #1;
    chk("t3_no_bypass", 8'(ba.ready_in), 8'h0);
    tick();
    chk("t3_drain1", 8'(ba.data_out0), 8'h2);
    chk("t3_ready_back", 8'(ba.ready_in), 8'h1);
    tick();
    chk("t3_drain2", 8'(ba.data_out0), 8'h1);
    ba.valid_in = 1'b0;
    tick();
    chk("t3_empty0", 8'(ba.valid_out0), 8'h0);
    chk("t3_empty1", 8'(ba.valid_out1), 8'h0);
    // T4 lane 1 full boundary (sel_q is 1 here)
    ba.ready_out0 = 1'b1; ba.ready_out1 = 1'b0;
    send_a(2'b01);
    send_a(2'b10);
    send_a(2'b11);
    send_a(2'b00);
    ba.data_in = 2'b10; ba.ready_out1 = 1'b1;
    #1;
    chk("t4_ready_full", 8'(ba.ready_in), 8'h0);
    tick();
    chk("t4_popped_head", 8'(ba.data_out1), 8'h3);
    chk("t4_ready_next", 8'(ba.ready_in), 8'h1);
    tick();
    chk("t4_accepted", 8'(ba.data_out1), 8'h2);
    ba.valid_in = 1'b0;
    tick();
    chk("t4_empty1", 8'(ba.valid_out1), 8'h0);
    // T5 explicit select on the AUTO_TOGGLE=0 instance
    bs.ready_out0 = 1'b1; bs.ready_out1 = 1'b1; bs.sel_in = 1'b1; bs.valid_in = 1'b1;
    bs.data_in = 2'b11;
    tick();
    chk("t5_w0", 8'(bs.data_out1), 8'h3);
    chk("t5_w0_lane0", 8'(bs.valid_out0), 8'h0);
    bs.data_in = 2'b01;
    tick();
    chk("t5_w1", 8'(bs.data_out1), 8'h1);
    bs.data_in = 2'b10;
    tick();
    chk("t5_w2", 8'(bs.data_out1), 8'h2);
    chk("t5_w2_lane0", 8'(bs.valid_out0), 8'h0);
    bs.valid_in = 1'b0;
    tick();
    chk("t5_empty", 8'({bs.valid_out0, bs.valid_out1}), 8'h0);
    // T6 mid-stream reset (sel_q is 0 here)
    ba.ready_out0 = 1'b0; ba.ready_out1 = 1'b0;
    send_a(2'b01);
    send_a(2'b10);
    send_a(2'b11);
    ba.valid_in = 1'b0;
    #1;
    chk("t6_buffered0", 8'(ba.valid_out0), 8'h1);
    chk("t6_buffered1", 8'(ba.valid_out1), 8'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_flush0", 8'(ba.valid_out0), 8'h0);
    chk("t6_flush1", 8'(ba.valid_out1), 8'h0);
    chk("t6_flush_data0", 8'(ba.data_out0), 8'h0);
    send_a(2'b10);
    ba.valid_in = 1'b0;
    chk("t6_lane0_after", 8'(ba.data_out0), 8'h2);
    chk("t6_lane0_valid", 8'(ba.valid_out0), 8'h1);
    chk("t6_lane1_idle", 8'(ba.valid_out1), 8'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
